// File: rtl/ntp_pkg.sv
// Shared NTP definitions: sequencer states, epoch offset and status bit positions.
// The VERIFY state is only reachable when NTP_SECONDS_VERIFY_EN is defined.
package ntp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PPS,
    WRITE,
    VERIFY,
    DONE
  } seqState_t;

  // Seconds between the NTP era-0 epoch (1900) and the POSIX epoch (1970).
  localparam logic [31:0] NTP_SECONDS_AT_POSIX_EPOCH = 32'd2208988800;

  localparam int PPS_VALID_BIT     = 0;
  localparam int SECONDS_VALID_BIT = 1;

endpackage

// File: rtl/ntp_seconds_sequencer_if.sv
// Bundle of requester handshakes, NTP clock status and the seconds write port.
// master = requesters / NTP clock side, slave = the sequencer.
interface ntp_seconds_sequencer_if;

  logic        reqA;
  logic        reqB;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        ackA;
  logic        ackB;
  logic        errA;
  logic        errB;
  logic        ppsToggle;
  logic        ppsValid;
  logic        secondsValid;
  logic        writeStrobe;
  logic [31:0] writeData;
  logic        busy;
  logic        lastOwner;

  modport master (
    output reqA, reqB, dataA, dataB, ppsToggle, ppsValid, secondsValid,
    input  ackA, ackB, errA, errB, writeStrobe, writeData, busy, lastOwner
  );

  modport slave (
    input  reqA, reqB, dataA, dataB, ppsToggle, ppsValid, secondsValid,
    output ackA, ackB, errA, errB, writeStrobe, writeData, busy, lastOwner
  );

endinterface

// File: rtl/ntp_seconds_sequencer_arbiter.sv
// Two-requester round-robin grant; on a tie the requester that did not own
// the port last time wins. lastOwner: 0 = A, 1 = B.
module ntp_rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic reqA,
  input  logic reqB,
  input  logic update,
  input  logic ownerB,
  output logic grantValid,
  output logic grantB,
  output logic lastOwner
);

  assign grantValid = reqA | reqB;
  assign grantB     = reqB & (~reqA | ~lastOwner);

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastOwner <= 1'b1;
    end else if (update) begin
      lastOwner <= ownerB;
    end
  end

endmodule

// File: rtl/ntp_seconds_sequencer.sv
// Arbitrates NTP seconds writes from two requesters and aligns each write to the
// cycle after a validated PPS edge. NTP_SECONDS_VERIFY_EN adds a secondsValid check.
module ntp_seconds_sequencer
  import ntp_pkg::*;
#(
  parameter int CLK_RATE      = 100000000,
  parameter int WAIT_TIMEOUT  = 2 * CLK_RATE,
  parameter int VERIFY_CYCLES = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  ntp_seconds_sequencer_if.slave  bus
);

  localparam int                WAIT_W     = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);

`ifdef NTP_SECONDS_VERIFY_EN
  localparam int                  VERIFY_W    = $clog2(VERIFY_CYCLES + 1);
  localparam logic [VERIFY_W-1:0] VERIFY_LAST = VERIFY_W'(VERIFY_CYCLES - 1);
  logic [VERIFY_W-1:0]            verifyCount;
`endif

  seqState_t         state;
  logic              ownerB;
  logic [31:0]       latchedData;
  logic [WAIT_W-1:0] waitCount;
  logic              ppsSeen;
  logic              ppsEdge;
  logic              grantValid;
  logic              grantB;
  logic              lastOwner;

  assign ppsEdge       = bus.ppsToggle ^ ppsSeen;
  assign bus.lastOwner = lastOwner;

  ntp_rr_arbiter2 arbiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .reqA       (bus.reqA),
    .reqB       (bus.reqB),
    .update     (state == DONE),
    .ownerB     (ownerB),
    .grantValid (grantValid),
    .grantB     (grantB),
    .lastOwner  (lastOwner)
  );

  // Edges seen while idle are dropped: latched data names the second that starts
  // at the next PPS after grant. ppsSeen follows the toggle even in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      ownerB          <= 1'b0;
      latchedData     <= '0;
      waitCount       <= '0;
      ppsSeen         <= bus.ppsToggle;
      bus.writeStrobe <= 1'b0;
      bus.writeData   <= '0;
      bus.ackA        <= 1'b0;
      bus.ackB        <= 1'b0;
      bus.errA        <= 1'b0;
      bus.errB        <= 1'b0;
      bus.busy        <= 1'b0;
`ifdef NTP_SECONDS_VERIFY_EN
      verifyCount     <= '0;
`endif
    end else begin
      ppsSeen         <= bus.ppsToggle;
      bus.writeStrobe <= 1'b0;
      bus.ackA        <= 1'b0;
      bus.ackB        <= 1'b0;
      bus.errA        <= 1'b0;
      bus.errB        <= 1'b0;

      case (state)
        IDLE: begin
          if (grantValid) begin
            state       <= WAIT_PPS;
            bus.busy    <= 1'b1;
            ownerB      <= grantB;
            latchedData <= grantB ? bus.dataB : bus.dataA;
            waitCount   <= '0;
          end
        end

        // Reaching the limit leaves the state, so the counter cannot wrap.
        WAIT_PPS: begin
          if (!bus.ppsValid || (waitCount == WAIT_LIMIT)) begin
            state    <= DONE;
            bus.ackA <= ~ownerB;
            bus.ackB <= ownerB;
            bus.errA <= ~ownerB;
            bus.errB <= ownerB;
          end else if (ppsEdge) begin
            state           <= WRITE;
            bus.writeStrobe <= 1'b1;
            bus.writeData   <= latchedData;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end

        WRITE: begin
`ifdef NTP_SECONDS_VERIFY_EN
          state       <= VERIFY;
          verifyCount <= '0;
`else
          state    <= DONE;
          bus.ackA <= ~ownerB;
          bus.ackB <= ownerB;
`endif
        end

`ifdef NTP_SECONDS_VERIFY_EN
        VERIFY: begin
          if (bus.secondsValid) begin
            state    <= DONE;
            bus.ackA <= ~ownerB;
            bus.ackB <= ownerB;
          end else if (verifyCount == VERIFY_LAST) begin
            state    <= DONE;
            bus.ackA <= ~ownerB;
            bus.ackB <= ownerB;
            bus.errA <= ~ownerB;
            bus.errB <= ownerB;
          end else begin
            verifyCount <= verifyCount + 1'b1;
          end
        end
`endif

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntp_seconds_sequencer.sv
// Directed bench for ntp_seconds_sequencer with a timeline model checked every cycle.
// Define NTP_SECONDS_VERIFY_EN to also cover the secondsValid check.
module tb_ntp_seconds_sequencer;

  localparam int WAIT_TO  = 100;
  localparam int VERIFY_N = 16;

  logic clk;
  logic rst_n;

  ntp_seconds_sequencer_if bus ();

  ntp_seconds_sequencer #(
    .CLK_RATE      (100000000),
    .WAIT_TIMEOUT  (WAIT_TO),
    .VERIFY_CYCLES (VERIFY_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] strobeQ[$];
  bit          ackQ[$];
  bit          errQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Timeline model: each transaction is a set of predicted edge numbers
  // (grant, strobe, ack) derived from the request, PPS and timeout rules.
  int          modelCycle = 0;
  bit          mActive    = 1'b0;
  bit          mOwnerB    = 1'b0;
  bit          mLast      = 1'b1;
  bit          mErr       = 1'b0;
  logic        mPrevTog   = 1'b0;
  int          mIdleFrom  = 0;
  int          mWaitStart = 0;
  int          mStrobeAt  = -1;
  int          mAckAt     = -1;
  logic [31:0] mData      = '0;
  logic [31:0] mWd        = '0;

  task automatic modelStep();
    modelCycle++;
    if (!rst_n) begin
      mActive   = 1'b0;
      mLast     = 1'b1;
      mWd       = '0;
      mStrobeAt = -1;
      mAckAt    = -1;
      mIdleFrom = modelCycle + 1;
      mPrevTog  = bus.ppsToggle;
      return;
    end
    if (mActive && mAckAt == modelCycle - 1) begin
      mActive   = 1'b0;
      mLast     = mOwnerB;
      mIdleFrom = modelCycle + 1;
    end
    if (!mActive) begin
      if (modelCycle >= mIdleFrom && (bus.reqA || bus.reqB)) begin
        mActive    = 1'b1;
        mOwnerB    = bus.reqB && (!bus.reqA || !mLast);
        mData      = mOwnerB ? bus.dataB : bus.dataA;
        mWaitStart = modelCycle + 1;
        mStrobeAt  = -1;
        mAckAt     = -1;
      end
    end else if (mAckAt < 0) begin
      if (mStrobeAt < 0) begin
        if (modelCycle >= mWaitStart) begin
          if (!bus.ppsValid || (modelCycle - mWaitStart) >= WAIT_TO) begin
            mAckAt = modelCycle;
            mErr   = 1'b1;
          end else if (bus.ppsToggle != mPrevTog) begin
            mStrobeAt = modelCycle;
            mWd       = mData;
`ifndef NTP_SECONDS_VERIFY_EN
            mAckAt    = modelCycle + 1;
            mErr      = 1'b0;
`endif
          end
        end
      end
`ifdef NTP_SECONDS_VERIFY_EN
      else if (modelCycle >= mStrobeAt + 2) begin
        if (bus.secondsValid) begin
          mAckAt = modelCycle;
          mErr   = 1'b0;
        end else if (modelCycle - (mStrobeAt + 2) == VERIFY_N - 1) begin
          mAckAt = modelCycle;
          mErr   = 1'b1;
        end
      end
`endif
    end
    mPrevTog = bus.ppsToggle;
  endtask

  always @(posedge clk) begin
    modelStep();
    #1;
    checkOutput("writeStrobe", 32'(bus.writeStrobe), 32'(mStrobeAt == modelCycle));
    checkOutput("ackA", 32'(bus.ackA), 32'(mAckAt == modelCycle && !mOwnerB));
    checkOutput("ackB", 32'(bus.ackB), 32'(mAckAt == modelCycle && mOwnerB));
    checkOutput("busy", 32'(bus.busy), 32'(mActive));
    checkOutput("lastOwner", 32'(bus.lastOwner), 32'(mLast));
    if (mStrobeAt == modelCycle) checkOutput("writeData", bus.writeData, mWd);
    if (mAckAt == modelCycle && !mOwnerB) checkOutput("errA", 32'(bus.errA), 32'(mErr));
    if (mAckAt == modelCycle && mOwnerB) checkOutput("errB", 32'(bus.errB), 32'(mErr));
  end

  // Runs the requesters and an optional periodic PPS; drops each req on its ack.
  task automatic applyStimulus(input int cycles, input int ppsPeriod);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.writeStrobe) strobeQ.push_back(bus.writeData);
      if (bus.ackA) begin
        ackQ.push_back(1'b0);
        errQ.push_back(bus.errA);
        bus.reqA = 1'b0;
      end
      if (bus.ackB) begin
        ackQ.push_back(1'b1);
        errQ.push_back(bus.errB);
        bus.reqB = 1'b0;
      end
      if (ppsPeriod > 0 && (i % ppsPeriod) == ppsPeriod - 1) bus.ppsToggle = ~bus.ppsToggle;
    end
  endtask

  task automatic clearQueues();
    strobeQ.delete();
    ackQ.delete();
    errQ.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    bit  sawStrobe;
    bit  gotAck;
    logic gotErr;

    rst_n            = 1'b0;
    bus.reqA         = 1'b0;
    bus.reqB         = 1'b0;
    bus.dataA        = '0;
    bus.dataB        = '0;
    bus.ppsToggle    = 1'b0;
    bus.ppsValid     = 1'b1;
    bus.secondsValid = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset writeStrobe", 32'(bus.writeStrobe), 32'd0);
    checkOutput("reset ack/err", {28'd0, bus.ackA, bus.ackB, bus.errA, bus.errB}, 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset writeData", bus.writeData, 32'd0);
    checkOutput("reset lastOwner", 32'(bus.lastOwner), 32'd1);
    rst_n = 1'b1;

    // Single A request, edge two cycles after grant.
    @(negedge clk);
    bus.dataA = 32'hE8D4A510;
    bus.reqA  = 1'b1;
    repeat (2) @(negedge clk);
    bus.ppsToggle = ~bus.ppsToggle;
    @(posedge clk); #1;
    checkOutput("t1 strobe at T+1", 32'(bus.writeStrobe), 32'd1);
    checkOutput("t1 writeData", bus.writeData, 32'hE8D4A510);
    @(posedge clk); #1;
`ifdef NTP_SECONDS_VERIFY_EN
    @(posedge clk); #1;
`endif
    checkOutput("t1 ackA", 32'(bus.ackA), 32'd1);
    checkOutput("t1 errA", 32'(bus.errA), 32'd0);
    @(negedge clk);
    bus.reqA = 1'b0;
    applyStimulus(3, 0);

    // Simultaneous A/B right after reset: A first, B on the following edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    bus.dataA = 32'hE8D4A511;
    bus.dataB = 32'hE8D4A522;
    bus.reqA  = 1'b1;
    bus.reqB  = 1'b1;
    clearQueues();
    applyStimulus(40, 6);
    checkOutput("t2 write count", strobeQ.size(), 32'd2);
    checkOutput("t2 first write", (strobeQ.size() > 0) ? strobeQ[0] : 32'hDEADBEEF, 32'hE8D4A511);
    checkOutput("t2 second write", (strobeQ.size() > 1) ? strobeQ[1] : 32'hDEADBEEF, 32'hE8D4A522);
    checkOutput("t2 first ack owner", (ackQ.size() > 0) ? 32'(ackQ[0]) : 32'hDEADBEEF, 32'd0);
    checkOutput("t2 second ack owner", (ackQ.size() > 1) ? 32'(ackQ[1]) : 32'hDEADBEEF, 32'd1);
    checkOutput("t2 lastOwner", 32'(bus.lastOwner), 32'd1);

    // ppsValid low at request: fails on the first waiting cycle, no write.
    bus.ppsValid = 1'b0;
    bus.dataA    = 32'h00000042;
    bus.reqA     = 1'b1;
    n = 0; sawStrobe = 1'b0; gotAck = 1'b0; gotErr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.writeStrobe) sawStrobe = 1'b1;
      if (bus.ackA) begin
        gotAck = 1'b1;
        gotErr = bus.errA;
        break;
      end
    end
    checkOutput("t3 ackA seen", 32'(gotAck), 32'd1);
    checkOutput("t3 errA", 32'(gotErr), 32'd1);
    checkOutput("t3 latency", n, 32'd2);
    checkOutput("t3 no strobe", 32'(sawStrobe), 32'd0);
    @(negedge clk);
    bus.reqA     = 1'b0;
    bus.ppsValid = 1'b1;
    applyStimulus(3, 0);

    // Timeout: no PPS edge for B.
    bus.dataB = 32'h12345678;
    bus.reqB  = 1'b1;
    n = 0; sawStrobe = 1'b0; gotAck = 1'b0; gotErr = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.writeStrobe) sawStrobe = 1'b1;
      if (bus.ackB) begin
        gotAck = 1'b1;
        gotErr = bus.errB;
        break;
      end
    end
    checkOutput("t4 ackB seen", 32'(gotAck), 32'd1);
    checkOutput("t4 errB", 32'(gotErr), 32'd1);
    checkOutput("t4 req-to-ack edges", n, 32'(WAIT_TO + 2));
    checkOutput("t4 no strobe", 32'(sawStrobe), 32'd0);
    @(negedge clk);
    bus.reqB = 1'b0;
    applyStimulus(3, 0);

    // Reset while waiting for PPS aborts silently; a later request completes.
    bus.dataA = 32'hAAAA5555;
    bus.reqA  = 1'b1;
    applyStimulus(5, 0);
    rst_n         = 1'b0;
    bus.reqA      = 1'b0;
    bus.ppsToggle = ~bus.ppsToggle;
    @(negedge clk);
    rst_n = 1'b1;
    clearQueues();
    applyStimulus(10, 0);
    checkOutput("t5 no strobe after abort", strobeQ.size(), 32'd0);
    checkOutput("t5 no ack after abort", ackQ.size(), 32'd0);
    bus.dataA = 32'hE8D4A600;
    bus.reqA  = 1'b1;
    applyStimulus(20, 5);
    checkOutput("t5 write count", strobeQ.size(), 32'd1);
    checkOutput("t5 write data", (strobeQ.size() > 0) ? strobeQ[0] : 32'hDEADBEEF, 32'hE8D4A600);
    checkOutput("t5 ack err", (errQ.size() > 0) ? 32'(errQ[0]) : 32'hDEADBEEF, 32'd0);
    checkOutput("t5 lastOwner", 32'(bus.lastOwner), 32'd0);

`ifdef NTP_SECONDS_VERIFY_EN
    // secondsValid never follows the write.
    bus.secondsValid = 1'b0;
    bus.dataA        = 32'h0BADF00D;
    bus.reqA         = 1'b1;
    repeat (2) @(negedge clk);
    bus.ppsToggle = ~bus.ppsToggle;
    @(posedge clk); #1;
    checkOutput("t6 strobe", 32'(bus.writeStrobe), 32'd1);
    n = 0; gotAck = 1'b0; gotErr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.ackA) begin
        gotAck = 1'b1;
        gotErr = bus.errA;
        break;
      end
    end
    checkOutput("t6 ackA seen", 32'(gotAck), 32'd1);
    checkOutput("t6 errA", 32'(gotErr), 32'd1);
    checkOutput("t6 strobe-to-ack", n, 32'(VERIFY_N + 1));
    @(negedge clk);
    bus.reqA         = 1'b0;
    bus.secondsValid = 1'b1;
`endif

    applyStimulus(3, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
